// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the ex stage; holds the pipeline until its rd write is ready.
// Optional macro EX_MULDIV_FAST_MUL_EN: single-cycle combinational MUL* at accept (DIV* stays iterative).
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_Clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_kill,
    input  logic [2:0]            i_op,
    input  logic [XLEN-1:0]       i_a,
    input  logic [XLEN-1:0]       i_b,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic                  o_hold,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_rd_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q;
    logic                    sa_q, sb_q;
    logic [XLEN-1:0]         dvs_q;
    logic [XLEN-1:0]         hi_q, lo_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [XLEN-1:0]         res_q;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

    // Accept-side decode: operand magnitudes, sign flags and the divide special cases.
    logic            accept, in_sa, in_sb, div_zero, div_ovf, special, fast_go;
    logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res;

    assign accept   = (state_q == IDLE) && i_start && !i_kill;
    assign in_sa    = a_is_signed(i_op) && i_a[XLEN-1];
    assign in_sb    = b_is_signed(i_op) && i_b[XLEN-1];
    assign abs_a    = in_sa ? -i_a : i_a;
    assign abs_b    = in_sb ? -i_b : i_b;
    assign div_zero = i_op[2] && (i_b == '0);
    assign div_ovf  = i_op[2] && !i_op[0] && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : i_a);

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_sprod;
    always_comb begin
        fast_prod  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
        fast_sprod = (in_sa ^ in_sb) ? -fast_prod : fast_prod;
        fast_res   = (i_op[1:0] == 2'b00) ? fast_sprod[XLEN-1:0] : fast_sprod[2*XLEN-1:XLEN];
    end
    assign fast_go = !i_op[2];
`else
    assign fast_res = '0;
    assign fast_go  = 1'b0;
`endif

    // One iteration: shift-add for MUL* ({hi,lo} = product), restoring step for DIV* (hi = rem, lo = quo).
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, quo, rem, calc_res;
    logic [2*XLEN-1:0] prod, sprod;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
        nxt_hi   = hi_q;
        nxt_lo   = lo_q;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, dvs_q};
        if (op_q[2]) begin
            nxt_hi = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            nxt_lo = {lo_q[XLEN-2:0], !div_diff[XLEN]};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {nxt_hi, nxt_lo};
        sprod    = (sa_q ^ sb_q) ? -prod : prod;
        quo      = (sa_q ^ sb_q) ? -nxt_lo : nxt_lo;
        rem      = sa_q ? -nxt_hi : nxt_hi;
        if (op_q[2])
            calc_res = op_q[1] ? rem : quo;
        else
            calc_res = (op_q[1:0] == 2'b00) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
    end

    logic last_iter;
    assign last_iter = (state_q == CALC) && (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (special || fast_go) ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_kill) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= i_op;
                sa_q  <= in_sa;
                sb_q  <= in_sb;
                dvs_q <= abs_b;
                hi_q  <= '0;
                lo_q  <= abs_a;
                cnt_q <= '0;
                rd_q  <= i_rd_addr;
                if (special)      res_q <= special_res;
                else if (fast_go) res_q <= fast_res;
            end else if (state_q == CALC) begin
                hi_q  <= nxt_hi;
                lo_q  <= nxt_lo;
                cnt_q <= cnt_q + 1'b1;
                if (last_iter) res_q <= calc_res;
            end
        end
    end

    assign o_hold    = accept || (state_q == CALC);
    assign o_busy    = (state_q != IDLE);
    assign o_valid   = (state_q == DONE) && !i_kill;
    assign o_rd_we   = o_valid && (rd_q != '0);
    assign o_rd_addr = rd_q;
    assign o_result  = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed vectors push expected rd writes, a monitor pops them on o_valid.
module tb_ex_muldiv;
    localparam int XLEN    = 32;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    logic        i_Clk, i_reset, i_start, i_kill;
    logic [2:0]  i_op;
    logic [31:0] i_a, i_b;
    logic [4:0]  i_rd_addr;
    logic        o_hold, o_busy, o_valid, o_rd_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_result;

    ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(5)) dut (
        .i_Clk(i_Clk), .i_reset(i_reset), .i_start(i_start), .i_kill(i_kill),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_rd_addr(i_rd_addr),
        .o_hold(o_hold), .o_busy(o_busy), .o_valid(o_valid), .o_rd_we(o_rd_we),
        .o_rd_addr(o_rd_addr), .o_result(o_result)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clk);
            #2;
            if (o_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", o_result, e.res);
                    check("rd_addr", {27'd0, o_rd_addr}, {27'd0, e.rd});
                    check("rd_we", {31'd0, o_rd_we}, {31'd0, e.we});
                end
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        int   lat, holds;
        bit   seen;
        exp_t e;
        e.res = exp;
        e.rd  = rd;
        e.we  = (rd != 5'd0);
        sb.push_back(e);
        @(negedge i_Clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b; i_rd_addr = rd;
        lat = 0; holds = 0; seen = 0;
        #1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (o_hold) holds++;
            @(posedge i_Clk);
            lat++;
            @(negedge i_Clk);
            #1;
            if (o_valid) seen = 1;
        end
        i_start = 1'b0;
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_hold"}, 32'(holds), 32'(exp_lat));
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_kill = 1'b0;
        i_op = 3'b000; i_a = '0; i_b = '0; i_rd_addr = '0;
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_rd_we", {31'd0, o_rd_we}, 32'd0);
        check("rst_hold", {31'd0, o_hold}, 32'd0);
        check("rst_rd_addr", {27'd0, o_rd_addr}, 32'd0);
        check("rst_result", o_result, 32'd0);
        repeat (2) @(negedge i_Clk);
        i_reset = 1'b0;

        run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mul_m5_m6", OP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd6, 32'd30, MUL_LAT);
        run_op("mulh", OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, MUL_LAT);
        run_op("mulhu", OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF, MUL_LAT);
        run_op("mulh_max", OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4, 32'h3FFF_FFFF, MUL_LAT);

        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd12, 32'h0FFF_FFFF, DIV_LAT);
        run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd13, 32'hFFFF_FFF2, DIV_LAT);
        run_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd14, 32'd2, DIV_LAT);

        run_op("div_by0", OP_DIV, 32'h0000_1234, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", OP_REM, 32'h0000_1234, 32'd0, 5'd16, 32'h0000_1234, 1);
        run_op("remu_by0", OP_REMU, 32'h0000_1234, 32'd0, 5'd17, 32'h0000_1234, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1);

        // Kill mid-CALC: no writeback may appear, and the unit must be idle at the next edge.
        @(negedge i_Clk);
        i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd3; i_rd_addr = 5'd7;
        @(posedge i_Clk);
        repeat (9) @(posedge i_Clk);
        @(negedge i_Clk);
        i_kill = 1'b1;
        #1;
        check("kill_busy_before", {31'd0, o_busy}, 32'd1);
        @(posedge i_Clk);
        #1;
        check("kill_busy_after", {31'd0, o_busy}, 32'd0);
        @(negedge i_Clk);
        i_kill = 1'b0; i_start = 1'b0;
        repeat (3) @(negedge i_Clk);
        run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 5'd8, 32'd12, MUL_LAT);

        // Kill and start together in IDLE: nothing is accepted.
        @(negedge i_Clk);
        i_start = 1'b1; i_kill = 1'b1; i_op = OP_MUL;
        @(posedge i_Clk);
        #1;
        check("kill_start_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_Clk);
        i_start = 1'b0; i_kill = 1'b0;

        // Kill in DONE suppresses the pulse combinationally.
        @(negedge i_Clk);
        i_start = 1'b1; i_op = OP_DIV; i_a = 32'h1234; i_b = 32'd0; i_rd_addr = 5'd3;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_kill = 1'b1;
        #1;
        check("kill_done_busy", {31'd0, o_busy}, 32'd1);
        check("kill_done_valid", {31'd0, o_valid}, 32'd0);
        check("kill_done_rd_we", {31'd0, o_rd_we}, 32'd0);
        i_start = 1'b0;
        @(posedge i_Clk);
        #1;
        check("kill_done_idle", {31'd0, o_busy}, 32'd0);
        @(negedge i_Clk);
        i_kill = 1'b0;

        run_op("mul_rd0", OP_MUL, 32'd2, 32'd3, 5'd0, 32'd6, MUL_LAT);

        // Reset mid-operation clears every output at once.
        @(negedge i_Clk);
        i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd25; i_b = 32'd5; i_rd_addr = 5'd9;
        repeat (5) @(posedge i_Clk);
        @(negedge i_Clk);
        i_start = 1'b0;
        i_reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_hold", {31'd0, o_hold}, 32'd0);
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_rd_addr", {27'd0, o_rd_addr}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        @(negedge i_Clk);
        i_reset = 1'b0;

        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, DIV_LAT);

        repeat (3) @(negedge i_Clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
